ram_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port synchronous RAM: shares one RAM instance between requester 0 (instruction fetch) and requester 1 (data load/store).
- Drives the RAM chip-enable, read/write, address and write-data pins, and returns read data to the winning requester.
- Default arbitration is round-robin; one RAM transaction is in flight at a time.
- Sits between the processor front end / load-store unit and the RAM.

---
 rtl/ram_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Shares one single-port synchronous RAM between two requesters:
//   requester 0 - instruction fetch
//   requester 1 - data load/store
// Only one RAM transaction is in flight at a time. A transaction is accepted
// in IDLE, drives ram_ce for exactly one cycle in ISSUE and, for reads,
// samples the RAM output in CAPTURE before pulsing the owner's rsp_valid.
//
// Arbitration: round-robin by default (when both requesters are valid, the
// one that did not win last time is granted). Defining the macro
// RAM_ARB_FIXED_PRIO_EN switches to fixed priority, where requester 0 always
// wins a tie and no last-grant history is kept.
//
// Parameters:
//   mem_width   data word width (must match the RAM)
//   add_length  address width   (must match the RAM)
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready     request handshake, accepted on valid & ready
//   reqN_write                  1 = write, 0 = read
//   reqN_addr / reqN_wdata      request address and write data
//   rspN_valid                  one-cycle pulse, rspN_rdata holds read result
//   rspN_rdata                  last read data for requester N (held)
//   ram_address / ram_in_data   registered RAM address and write data
//   ram_rr                      RAM read/write select, 1 = write
//   ram_ce                      RAM chip enable, high for one cycle per access
//   ram_out_data                RAM read data (only meaningful in CAPTURE)
// ---------------------------------------------------------------------------
module ram_arbiter #(
    parameter int mem_width  = 16,
    parameter int add_length = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_write,
    input  logic [add_length-1:0] req0_addr,
    input  logic [mem_width-1:0]  req0_wdata,
    output logic                  rsp0_valid,
    output logic [mem_width-1:0]  rsp0_rdata,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_write,
    input  logic [add_length-1:0] req1_addr,
    input  logic [mem_width-1:0]  req1_wdata,
    output logic                  rsp1_valid,
    output logic [mem_width-1:0]  rsp1_rdata,

    output logic [add_length-1:0] ram_address,
    output logic [mem_width-1:0]  ram_in_data,
    output logic                  ram_rr,
    output logic                  ram_ce,
    input  logic [mem_width-1:0]  ram_out_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic [add_length-1:0] addr_q, addr_d;
    logic [mem_width-1:0]  wdata_q, wdata_d;
    logic                  rr_q, rr_d;
    logic                  ce_q, ce_d;
    logic                  rsp0_valid_q, rsp0_valid_d;
    logic                  rsp1_valid_q, rsp1_valid_d;
    logic [mem_width-1:0]  rsp0_rdata_q, rsp0_rdata_d;
    logic [mem_width-1:0]  rsp1_rdata_q, rsp1_rdata_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
    logic                  last_grant_q, last_grant_d;
`endif

    // Combinational grant, evaluated every cycle but only acted on in IDLE.
    logic                  gnt_valid;
    logic                  gnt_id;

    // Fields of the winning request.
    logic                  win_write;
    logic [add_length-1:0] win_addr;
    logic [mem_width-1:0]  win_wdata;

    // -----------------------------------------------------------------------
    // Grant selection
    // -----------------------------------------------------------------------
    always_comb begin
        gnt_valid = req0_valid | req1_valid;
`ifdef RAM_ARB_FIXED_PRIO_EN
        // Requester 0 wins whenever it is valid.
        gnt_id = ~req0_valid;
`else
        // On a tie the requester that did not win last time is granted;
        // otherwise whichever one is asking.
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_grant_q;
        end else begin
            gnt_id = ~req0_valid;
        end
`endif
    end

    always_comb begin
        win_write = gnt_id ? req1_write : req0_write;
        win_addr  = gnt_id ? req1_addr  : req0_addr;
        win_wdata = gnt_id ? req1_wdata : req0_wdata;
    end

    // -----------------------------------------------------------------------
    // State register (all flops, async active-low reset)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rr_q         <= 1'b0;
            // Forcing ce low asynchronously keeps an aborted access from
            // touching the RAM at the next edge.
            ce_q         <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            // Pretend requester 1 won last so requester 0 wins the first tie.
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rr_q         <= rr_d;
            ce_q         <= ce_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rr_d         = rr_q;
        ce_d         = ce_q;
        // Response valids are pulses: low unless set below.
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    addr_d       = win_addr;
                    wdata_d      = win_wdata;
                    rr_d         = win_write;
                    ce_d         = 1'b1;
                    owner_d      = gnt_id;
`ifndef RAM_ARB_FIXED_PRIO_EN
                    last_grant_d = gnt_id;
`endif
                    state_d      = ISSUE;
                end
            end

            ISSUE: begin
                // The RAM performs the access on the edge closing this cycle.
                ce_d = 1'b0;
                if (rr_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = CAPTURE;
                end
            end

            CAPTURE: begin
                // ram_out_data is only sampled here; elsewhere it may be Z.
                if (owner_q) begin
                    rsp1_rdata_d = ram_out_data;
                    rsp1_valid_d = 1'b1;
                end else begin
                    rsp0_rdata_d = ram_out_data;
                    rsp0_valid_d = 1'b1;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                ce_d    = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        req0_ready  = (state_q == IDLE) && gnt_valid && !gnt_id;
        req1_ready  = (state_q == IDLE) && gnt_valid &&  gnt_id;
        ram_address = addr_q;
        ram_in_data = wdata_q;
        ram_rr      = rr_q;
        ram_ce      = ce_q;
        rsp0_valid  = rsp0_valid_q;
        rsp1_valid  = rsp1_valid_q;
        rsp0_rdata  = rsp0_rdata_q;
        rsp1_rdata  = rsp1_rdata_q;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    localparam int MW = 16;
    localparam int AL = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req0_valid = 1'b0, req0_write = 1'b0;
    logic [AL-1:0] req0_addr = '0;
    logic [MW-1:0] req0_wdata = '0;
    logic          req1_valid = 1'b0, req1_write = 1'b0;
    logic [AL-1:0] req1_addr = '0;
    logic [MW-1:0] req1_wdata = '0;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [MW-1:0] rsp0_rdata, rsp1_rdata;
    logic [AL-1:0] ram_address;
    logic [MW-1:0] ram_in_data;
    logic          ram_rr, ram_ce;
    logic [MW-1:0] ram_out_data = 'z;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic ticked = 1'b0;
    logic prev0 = 1'b0, prev1 = 1'b0;

    // Scoreboard: expected read data per port, pushed at accept time.
    logic [MW-1:0] q0[$];
    logic [MW-1:0] q1[$];
    // Bench-side model of what the RAM should contain.
    logic [MW-1:0] model[8];
    // The RAM itself.
    logic [MW-1:0] ram_mem[8];

    ram_arbiter #(.mem_width(MW), .add_length(AL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_address(ram_address), .ram_in_data(ram_in_data),
        .ram_rr(ram_rr), .ram_ce(ram_ce), .ram_out_data(ram_out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port synchronous RAM: output is Z except after a read edge.
    always @(posedge clk) begin
        if (ram_ce === 1'b1) begin
            if (ram_rr) begin
                ram_mem[ram_address] <= ram_in_data;
                ram_out_data <= 'z;
            end else begin
                ram_out_data <= ram_mem[ram_address];
            end
        end else begin
            ram_out_data <= 'z;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observe one cycle at the falling edge; scoreboard any response pulse.
    task automatic tick();
        @(negedge clk);
        ticked = 1'b1;
        if (rst_n) begin
            if (rsp0_valid === 1'b1) begin
                checks++;
                if (q0.size() == 0 || prev0) begin
                    errors++;
                    $display("FAIL rsp0_unexpected: rsp0_valid=1 required 0 (cycle %0d)", cyc);
                end else begin
                    logic [MW-1:0] e0;
                    e0 = q0.pop_front();
                    if (rsp0_rdata !== e0) begin
                        errors++;
                        $display("FAIL rsp0_data: rsp0_rdata=%h required %h", rsp0_rdata, e0);
                    end
                end
            end
            if (rsp1_valid === 1'b1) begin
                checks++;
                if (q1.size() == 0 || prev1) begin
                    errors++;
                    $display("FAIL rsp1_unexpected: rsp1_valid=1 required 0 (cycle %0d)", cyc);
                end else begin
                    logic [MW-1:0] e1;
                    e1 = q1.pop_front();
                    if (rsp1_rdata !== e1) begin
                        errors++;
                        $display("FAIL rsp1_data: rsp1_rdata=%h required %h", rsp1_rdata, e1);
                    end
                end
            end
        end
        prev0 = rst_n & (rsp0_valid === 1'b1);
        prev1 = rst_n & (rsp1_valid === 1'b1);
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic step();
        if (!ticked) tick();
        @(posedge clk);
        #1;
        ticked = 1'b0;
    endtask

    task automatic drive(input int port, input logic v, input logic wr,
                         input logic [AL-1:0] a, input logic [MW-1:0] d);
        if (port == 0) begin
            req0_valid = v; req0_write = wr; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_write = wr; req1_addr = a; req1_wdata = d;
        end
    endtask

    // Present one request and wait (bounded) for it to be accepted. Returns
    // just after the accept edge. 'complete' = the access is expected to finish.
    task automatic issue(input int port, input logic wr, input logic [AL-1:0] a,
                         input logic [MW-1:0] d, input logic complete, output int acc_cyc);
        logic got;
        got = 1'b0;
        drive(port, 1'b1, wr, a, d);
        for (int n = 0; n < 30 && !got; n++) begin
            tick();
            if (((port == 0) ? req0_ready : req1_ready) === 1'b1) begin
                got = 1'b1;
                if (complete) begin
                    if (wr) model[a] = d;
                    else if (port == 0) q0.push_back(model[a]);
                    else q1.push_back(model[a]);
                end
            end
            step();
        end
        acc_cyc = cyc;
        drive(port, 1'b0, wr, a, d);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout: port %0d ready=0 required 1 within 30 cycles", port);
        end
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 8; n++) step();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: pending responses q0=%0d q1=%0d required 0", name, q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ram_ce, ram_rr} !== 2'b00) begin
            errors++; $display("FAIL reset_ce_rr: ce,rr=%b required 00", {ram_ce, ram_rr});
        end
        checks++;
        if (ram_address !== '0 || ram_in_data !== '0) begin
            errors++; $display("FAIL reset_addr_data: addr=%h data=%h required 0", ram_address, ram_in_data);
        end
        checks++;
        if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 4'b0) begin
            errors++; $display("FAIL reset_handshake: rsp/ready=%b required 0000",
                               {rsp0_valid, rsp1_valid, req0_ready, req1_ready});
        end
        checks++;
        if (rsp0_rdata !== '0 || rsp1_rdata !== '0) begin
            errors++; $display("FAIL reset_rdata: rdata0=%h rdata1=%h required 0", rsp0_rdata, rsp1_rdata);
        end
        step(); step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_idle();
        for (int n = 0; n < 20; n++) begin
            tick();
            checks++;
            if ({ram_ce, req0_ready, req1_ready} !== 3'b000) begin
                errors++; $display("FAIL idle_ce_ready: ce,ready0,ready1=%b required 000",
                                   {ram_ce, req0_ready, req1_ready});
            end
            checks++;
            if (rsp0_rdata !== '0 || rsp1_rdata !== '0) begin
                errors++; $display("FAIL idle_rdata: rdata0=%h rdata1=%h required 0", rsp0_rdata, rsp1_rdata);
            end
            step();
        end
    endtask

    task automatic test_write_req0();
        drive(0, 1'b1, 1'b1, 3'd3, 16'hA5A5);
        tick();
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL wr_ready: ready0=%b ready1=%b required 1 0", req0_ready, req1_ready);
        end
        model[3] = 16'hA5A5;
        step();
        drive(0, 1'b0, 1'b1, 3'd3, 16'hA5A5);
        tick();
        checks++;
        if ({ram_ce, ram_rr} !== 2'b11 || ram_address !== 3'd3 || ram_in_data !== 16'hA5A5) begin
            errors++; $display("FAIL wr_issue: ce=%b rr=%b addr=%0d data=%h required 1 1 3 a5a5",
                               ram_ce, ram_rr, ram_address, ram_in_data);
        end
        checks++;
        if (req0_ready !== 1'b0) begin
            errors++; $display("FAIL wr_ready_busy: ready0=%b required 0", req0_ready);
        end
        step();
        tick();
        checks++;
        if (ram_ce !== 1'b0) begin
            errors++; $display("FAIL wr_ce_one_cycle: ce=%b required 0", ram_ce);
        end
        step();
        drain("write_req0");
    endtask

    task automatic test_read_req1();
        int acc;
        logic [2:0] seen;
        logic [MW-1:0] data_at_pulse;
        issue(1, 1'b0, 3'd3, '0, 1'b1, acc);
        for (int n = 0; n < 4; n++) begin
            tick();
            seen[n % 3] = rsp1_valid;
            if (n == 2) data_at_pulse = rsp1_rdata;
            checks++;
            if (rsp0_valid !== 1'b0) begin
                errors++; $display("FAIL rd_rsp0_quiet: rsp0_valid=%b required 0", rsp0_valid);
            end
            if (n == 3) begin
                checks++;
                if (rsp1_valid !== 1'b0) begin
                    errors++; $display("FAIL rd_pulse_end: rsp1_valid=%b required 0", rsp1_valid);
                end
            end
            step();
        end
        checks++;
        if (seen !== 3'b100 || data_at_pulse !== 16'hA5A5) begin
            errors++; $display("FAIL rd_latency: rsp1_valid over 3 cycles=%b data=%h required 100 a5a5",
                               seen, data_at_pulse);
        end
    endtask

    task automatic test_round_robin();
        int acc, n_gnt;
        int gnt[4];
        int exp_gnt[4];
`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_gnt = '{0, 0, 0, 0};
`else
        exp_gnt = '{0, 1, 0, 1};
`endif
        // Preload through requester 1 so requester 0 wins the first tie.
        issue(1, 1'b1, 3'd1, 16'h0011, 1'b1, acc);
        issue(1, 1'b1, 3'd2, 16'h0022, 1'b1, acc);
        drive(0, 1'b1, 1'b0, 3'd1, '0);
        drive(1, 1'b1, 1'b0, 3'd2, '0);
        n_gnt = 0;
        for (int n = 0; n < 40 && n_gnt < 4; n++) begin
            tick();
            if (req0_ready === 1'b1) begin
                gnt[n_gnt] = 0; n_gnt++; q0.push_back(model[1]);
            end
            if (req1_ready === 1'b1 && n_gnt < 4) begin
                gnt[n_gnt] = 1; n_gnt++; q1.push_back(model[2]);
            end
            step();
        end
        drive(0, 1'b0, 1'b0, 3'd1, '0);
        drive(1, 1'b0, 1'b0, 3'd2, '0);
        checks++;
        if (n_gnt != 4) begin
            errors++; $display("FAIL rr_grant_count: grants=%0d required 4", n_gnt);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (gnt[i] != exp_gnt[i]) begin
                    errors++; $display("FAIL rr_grant_order: grant[%0d]=%0d required %0d", i, gnt[i], exp_gnt[i]);
                end
            end
        end
        drain("round_robin");
    endtask

    task automatic test_back_to_back();
        int acc, prev_acc;
        prev_acc = 0;
        for (int i = 0; i < 8; i++) begin
            logic [AL-1:0] a;
            a = AL'(i);
            issue(0, 1'b1, a, 16'(i * 16'h0101), 1'b1, acc);
            if (i > 0) begin
                checks++;
                if (acc - prev_acc != 2) begin
                    errors++; $display("FAIL b2b_wr_spacing: %0d cycles required 2", acc - prev_acc);
                end
            end
            prev_acc = acc;
        end
        for (int i = 0; i < 8; i++) begin
            logic [AL-1:0] a;
            a = AL'(i);
            issue(0, 1'b0, a, '0, 1'b1, acc);
            if (i > 0) begin
                checks++;
                if (acc - prev_acc != 3) begin
                    errors++; $display("FAIL b2b_rd_spacing: %0d cycles required 3", acc - prev_acc);
                end
            end
            prev_acc = acc;
        end
        drain("back_to_back");
    endtask

    task automatic test_reset_mid();
        int acc;
        logic got;
        // Abort a write while ce is high: the RAM must not see the edge.
        issue(0, 1'b1, 3'd6, 16'hDEAD, 1'b0, acc);
        rst_n = 1'b0;
        #1;
        checks++;
        if (ram_ce !== 1'b0) begin
            errors++; $display("FAIL rst_issue_ce: ce=%b required 0", ram_ce);
        end
        step(); step();
        rst_n = 1'b1;
        step();
        // Abort a read in CAPTURE: no response pulse afterwards.
        issue(1, 1'b0, 3'd4, '0, 1'b0, acc);
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (ram_ce !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++; $display("FAIL rst_capture: ce=%b rsp1_valid=%b required 0 0", ram_ce, rsp1_valid);
        end
        step(); step();
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if ({rsp0_valid, rsp1_valid} !== 2'b00 || rsp1_rdata !== '0) begin
                errors++; $display("FAIL rst_no_rsp: rsp_valid=%b rdata1=%h required 00 0",
                                   {rsp0_valid, rsp1_valid}, rsp1_rdata);
            end
            step();
        end
        // First tie after reset goes to requester 0.
        drive(0, 1'b1, 1'b0, 3'd5, '0);
        drive(1, 1'b1, 1'b0, 3'd4, '0);
        tick();
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL rst_first_grant: ready0=%b ready1=%b required 1 0", req0_ready, req1_ready);
        end
        if (req0_ready === 1'b1) q0.push_back(model[5]);
        step();
        drive(0, 1'b0, 1'b0, 3'd5, '0);
        got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            tick();
            if (req1_ready === 1'b1) begin
                got = 1'b1; q1.push_back(model[4]);
            end
            step();
        end
        drive(1, 1'b0, 1'b0, 3'd4, '0);
        checks++;
        if (!got) begin
            errors++; $display("FAIL rst_req1_timeout: ready1=0 required 1 within 30 cycles");
        end
        // RAM contents survive both resets, including the aborted write.
        for (int i = 0; i < 8; i++) begin
            logic [AL-1:0] a;
            a = AL'(i);
            issue(0, 1'b0, a, '0, 1'b1, acc);
        end
        drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_idle();
        test_write_req0();
        test_read_req1();
        test_round_robin();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
